// File: rtl/instruction_input_issuer.sv
// Producer-side driver for the move/immediate instruction input interface.
// Buffers decoded requests in an in-order FIFO and holds each one on its channel(s) until acknowledged.
module instruction_input_issuer #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 4,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               in_op,
  input  logic [ADDR_WIDTH-1:0]    in_move_from,
  input  logic [DATA_WIDTH-1:0]    in_immediate,
  output logic [ADDR_WIDTH-1:0]    move_from,
  output logic                     move_valid,
  input  logic                     move_ack,
  output logic [DATA_WIDTH-1:0]    immediate,
  output logic                     immediate_valid,
  input  logic                     immediate_ack,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [COUNT_WIDTH-1:0]   move_count,
  output logic [COUNT_WIDTH-1:0]   imm_count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t state, next_state;

  logic [1:0]            op_mem   [DEPTH];
  logic [ADDR_WIDTH-1:0] from_mem [DEPTH];
  logic [DATA_WIDTH-1:0] imm_mem  [DEPTH];

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             fifo_empty, fifo_full;
  logic             push, pop;
  logic             move_left, imm_left;
  logic [1:0]       head_op;

  assign fifo_level = wr_ptr - rd_ptr;
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (fifo_level == PTR_W'(DEPTH));
  assign in_ready   = !fifo_full;
  // NOPs complete the upstream handshake but never occupy a slot.
  assign push       = in_valid && in_ready && (in_op != 2'b00);
  assign head_op    = op_mem[rd_ptr[IDX_W-1:0]];
  assign busy       = !fifo_empty || move_valid || immediate_valid;

  assign move_left  = move_valid && !move_ack;
  assign imm_left   = immediate_valid && !immediate_ack;

  always_ff @(posedge clk) begin
    if (push) begin
      op_mem[wr_ptr[IDX_W-1:0]]   <= in_op;
      from_mem[wr_ptr[IDX_W-1:0]] <= in_move_from;
      imm_mem[wr_ptr[IDX_W-1:0]]  <= in_immediate;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Pop decisions look only at entries already stored, so a same-cycle push never re-arms.
  always_comb begin
    next_state = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          next_state = ISSUE;
        end
      end
      ISSUE: begin
        if (!move_left && !imm_left) begin
          if (!fifo_empty) pop = 1'b1;
          else             next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      move_from       <= '0;
      immediate       <= '0;
      move_valid      <= 1'b0;
      immediate_valid <= 1'b0;
    end else if (pop) begin
      move_from       <= from_mem[rd_ptr[IDX_W-1:0]];
      immediate       <= imm_mem[rd_ptr[IDX_W-1:0]];
      move_valid      <= head_op[0];
      immediate_valid <= head_op[1];
    end else begin
      move_valid      <= move_left;
      immediate_valid <= imm_left;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      move_count <= '0;
      imm_count  <= '0;
    end else begin
      if (move_valid && move_ack)           move_count <= move_count + COUNT_WIDTH'(1);
      if (immediate_valid && immediate_ack) imm_count  <= imm_count + COUNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_instruction_input_issuer.sv
// Scoreboard bench for instruction_input_issuer: expected channel values are queued on push
// and compared when the matching handshake is observed.
module tb_instruction_input_issuer;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int DEPTH = 4;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [1:0]    in_op = 2'b00;
  logic [AW-1:0] in_move_from = '0;
  logic [DW-1:0] in_immediate = '0;
  logic [AW-1:0] move_from;
  logic          move_valid;
  logic          move_ack = 1'b0;
  logic [DW-1:0] immediate;
  logic          immediate_valid;
  logic          immediate_ack = 1'b0;
  logic          busy;
  logic [$clog2(DEPTH):0] fifo_level;
  logic [CW-1:0] move_count;
  logic [CW-1:0] imm_count;

  int checks = 0;
  int errors = 0;

  logic [AW-1:0] exp_move_q[$];
  logic [DW-1:0] exp_imm_q[$];
  logic [CW-1:0] exp_move_cnt = '0;
  logic [CW-1:0] exp_imm_cnt = '0;

  logic          prev_mv = 1'b0, prev_ma = 1'b0, prev_iv = 1'b0, prev_ia = 1'b0;
  logic [AW-1:0] prev_from = '0;
  logic [DW-1:0] prev_imm = '0;

  always #5 clk = ~clk;

  instruction_input_issuer #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .COUNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_move_from(in_move_from), .in_immediate(in_immediate),
    .move_from(move_from), .move_valid(move_valid), .move_ack(move_ack),
    .immediate(immediate), .immediate_valid(immediate_valid), .immediate_ack(immediate_ack),
    .busy(busy), .fifo_level(fifo_level), .move_count(move_count), .imm_count(imm_count)
  );

  // Inputs only change just after a rising edge, so a handshake seen here completes on the next edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_mv = 1'b0;
      prev_iv = 1'b0;
    end else begin
      if (prev_mv && !prev_ma) begin
        checks++;
        if (move_valid !== 1'b1 || move_from !== prev_from) begin
          errors++;
          $display("[TB] FAIL move_hold: valid=%b from=%h, required valid=1 from=%h", move_valid, move_from, prev_from);
        end
      end
      if (prev_iv && !prev_ia) begin
        checks++;
        if (immediate_valid !== 1'b1 || immediate !== prev_imm) begin
          errors++;
          $display("[TB] FAIL imm_hold: valid=%b imm=%h, required valid=1 imm=%h", immediate_valid, immediate, prev_imm);
        end
      end
      if (move_valid && move_ack) begin
        checks++;
        exp_move_cnt = exp_move_cnt + 1'b1;
        if (exp_move_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL move_issue: unexpected from=%h, required no move", move_from);
        end else begin
          logic [AW-1:0] e;
          e = exp_move_q.pop_front();
          if (move_from !== e) begin
            errors++;
            $display("[TB] FAIL move_data: from=%h, required %h", move_from, e);
          end
        end
      end
      if (immediate_valid && immediate_ack) begin
        checks++;
        exp_imm_cnt = exp_imm_cnt + 1'b1;
        if (exp_imm_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL imm_issue: unexpected imm=%h, required no immediate", immediate);
        end else begin
          logic [DW-1:0] e;
          e = exp_imm_q.pop_front();
          if (immediate !== e) begin
            errors++;
            $display("[TB] FAIL imm_data: imm=%h, required %h", immediate, e);
          end
        end
      end
      prev_mv = move_valid;
      prev_ma = move_ack;
      prev_from = move_from;
      prev_iv = immediate_valid;
      prev_ia = immediate_ack;
      prev_imm = immediate;
    end
  end

  task automatic push_req(input logic [1:0] op, input logic [AW-1:0] from, input logic [DW-1:0] imm);
    int waited = 0;
    in_valid = 1'b1;
    in_op = op;
    in_move_from = from;
    in_immediate = imm;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL push_timeout: in_ready=%b, required 1", in_ready);
    end else begin
      if (op[0]) exp_move_q.push_back(from);
      if (op[1]) exp_imm_q.push_back(imm);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_op = 2'b00;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (busy !== 1'b0 || exp_move_q.size() != 0 || exp_imm_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: busy=%b pending_move=%0d pending_imm=%0d, required 0/0/0",
               busy, exp_move_q.size(), exp_imm_q.size());
    end
  endtask

  task automatic check_counts(input logic [CW-1:0] mv, input logic [CW-1:0] im);
    checks++;
    if (move_count !== mv || imm_count !== im || move_count !== exp_move_cnt || imm_count !== exp_imm_cnt) begin
      errors++;
      $display("[TB] FAIL counts: move=%0d imm=%0d, required move=%0d imm=%0d (observed %0d/%0d)",
               move_count, imm_count, mv, im, exp_move_cnt, exp_imm_cnt);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (in_ready !== 1'b1 || move_valid !== 1'b0 || immediate_valid !== 1'b0 || busy !== 1'b0 ||
        fifo_level !== 0 || move_from !== 0 || immediate !== 0) begin
      errors++;
      $display("[TB] FAIL reset_state: rdy=%b mv=%b iv=%b busy=%b lvl=%0d from=%h imm=%h, required 1 0 0 0 0 0 0",
               in_ready, move_valid, immediate_valid, busy, fifo_level, move_from, immediate);
    end
    check_counts(0, 0);
  endtask

  task automatic test_move_stall();
    push_req(2'b01, 8'h12, 32'h0);
    checks++;
    if (move_valid !== 1'b0 || fifo_level !== 1 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL move_accept: mv=%b lvl=%0d busy=%b, required 0 1 1", move_valid, fifo_level, busy);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (move_valid !== 1'b1 || move_from !== 8'h12 || fifo_level !== 0) begin
        errors++;
        $display("[TB] FAIL move_latency: mv=%b from=%h lvl=%0d, required 1 12 0", move_valid, move_from, fifo_level);
      end
    end
    move_ack = 1'b1;
    @(posedge clk); #1;
    move_ack = 1'b0;
    checks++;
    if (move_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL move_done: mv=%b busy=%b, required 0 0", move_valid, busy);
    end
    check_counts(1, 0);
  endtask

  task automatic test_back_to_back();
    move_ack = 1'b1;
    immediate_ack = 1'b1;
    push_req(2'b10, 8'h00, 32'hDEADBEEF);
    push_req(2'b01, 8'h05, 32'h0);
    checks++;
    if (immediate_valid !== 1'b1 || move_valid !== 1'b0 || immediate !== 32'hDEADBEEF) begin
      errors++;
      $display("[TB] FAIL b2b_imm: iv=%b mv=%b imm=%h, required 1 0 deadbeef", immediate_valid, move_valid, immediate);
    end
    push_req(2'b00, 8'hEE, 32'hEEEEEEEE);
    checks++;
    if (immediate_valid !== 1'b0 || move_valid !== 1'b1 || move_from !== 8'h05) begin
      errors++;
      $display("[TB] FAIL b2b_move: iv=%b mv=%b from=%h, required 0 1 05", immediate_valid, move_valid, move_from);
    end
    @(posedge clk); #1;
    checks++;
    if (immediate_valid !== 1'b0 || move_valid !== 1'b0 || fifo_level !== 0) begin
      errors++;
      $display("[TB] FAIL b2b_nop: iv=%b mv=%b lvl=%0d, required 0 0 0", immediate_valid, move_valid, fifo_level);
    end
    wait_idle();
    move_ack = 1'b0;
    immediate_ack = 1'b0;
    check_counts(2, 1);
  endtask

  task automatic test_move_imm_order();
    push_req(2'b11, 8'h03, 32'h7);
    push_req(2'b01, 8'h44, 32'h0);
    checks++;
    if (move_valid !== 1'b1 || immediate_valid !== 1'b1 || move_from !== 8'h03 || immediate !== 32'h7) begin
      errors++;
      $display("[TB] FAIL mi_issue: mv=%b iv=%b from=%h imm=%h, required 1 1 03 7", move_valid, immediate_valid, move_from, immediate);
    end
    immediate_ack = 1'b1;
    @(posedge clk); #1;
    immediate_ack = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (immediate_valid !== 1'b0 || move_valid !== 1'b1 || move_from !== 8'h03 || fifo_level !== 1) begin
        errors++;
        $display("[TB] FAIL mi_wait: iv=%b mv=%b from=%h lvl=%0d, required 0 1 03 1", immediate_valid, move_valid, move_from, fifo_level);
      end
      if (i == 0) begin
        @(posedge clk); #1;
      end
    end
    move_ack = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (move_valid !== 1'b1 || move_from !== 8'h44 || immediate_valid !== 1'b0 || fifo_level !== 0) begin
      errors++;
      $display("[TB] FAIL mi_rearm: mv=%b from=%h iv=%b lvl=%0d, required 1 44 0 0", move_valid, move_from, immediate_valid, fifo_level);
    end
    wait_idle();
    move_ack = 1'b0;
    check_counts(4, 2);
  endtask

  task automatic test_full();
    for (int i = 0; i < 5; i++) push_req(2'b01, AW'(8'hA0 + i), 32'h0);
    checks++;
    if (fifo_level !== 4 || in_ready !== 1'b0 || move_valid !== 1'b1 || move_from !== 8'hA0) begin
      errors++;
      $display("[TB] FAIL full_state: lvl=%0d rdy=%b mv=%b from=%h, required 4 0 1 a0", fifo_level, in_ready, move_valid, move_from);
    end
    in_valid = 1'b1;
    in_op = 2'b01;
    in_move_from = 8'hA5;
    exp_move_q.push_back(8'hA5);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b0 || fifo_level !== 4) begin
        errors++;
        $display("[TB] FAIL full_stall: rdy=%b lvl=%0d, required 0 4", in_ready, fifo_level);
      end
    end
    move_ack = 1'b1;
    @(posedge clk); #1;
    move_ack = 1'b0;
    checks++;
    if (fifo_level !== 3 || in_ready !== 1'b1 || move_from !== 8'hA1 || move_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL full_pop: lvl=%0d rdy=%b from=%h mv=%b, required 3 1 a1 1", fifo_level, in_ready, move_from, move_valid);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_op = 2'b00;
    checks++;
    if (fifo_level !== 4 || in_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL full_sixth: lvl=%0d rdy=%b, required 4 0", fifo_level, in_ready);
    end
    move_ack = 1'b1;
    wait_idle();
    move_ack = 1'b0;
    check_counts(10, 2);
  endtask

  task automatic test_reset_mid();
    push_req(2'b11, 8'h21, 32'h1111);
    push_req(2'b01, 8'h22, 32'h0);
    push_req(2'b10, 8'h00, 32'h3333);
    checks++;
    if (fifo_level !== 2 || move_valid !== 1'b1 || immediate_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rst_pre: lvl=%0d mv=%b iv=%b, required 2 1 1", fifo_level, move_valid, immediate_valid);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (move_valid !== 1'b0 || immediate_valid !== 1'b0 || fifo_level !== 0 || move_count !== 0 || imm_count !== 0) begin
      errors++;
      $display("[TB] FAIL rst_async: mv=%b iv=%b lvl=%0d mc=%0d ic=%0d, required all 0",
               move_valid, immediate_valid, fifo_level, move_count, imm_count);
    end
    exp_move_q.delete();
    exp_imm_q.delete();
    exp_move_cnt = '0;
    exp_imm_cnt = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    move_ack = 1'b1;
    immediate_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b1 || move_valid !== 1'b0 || immediate_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("[TB] FAIL rst_stale: rdy=%b mv=%b iv=%b busy=%b, required 1 0 0 0", in_ready, move_valid, immediate_valid, busy);
      end
    end
    move_ack = 1'b0;
    immediate_ack = 1'b0;
    check_counts(0, 0);
  endtask

  task automatic test_count_wrap();
    move_ack = 1'b1;
    for (int i = 0; i < 65535; i++) push_req(2'b01, AW'(i), 32'h0);
    wait_idle();
    check_counts(16'hFFFF, 0);
    push_req(2'b01, 8'h5A, 32'h0);
    wait_idle();
    move_ack = 1'b0;
    check_counts(16'h0000, 0);
  endtask

  initial begin
    #1_500_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_move_stall();
    test_back_to_back();
    test_move_imm_order();
    test_full();
    test_reset_mid();
    test_count_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_input_issuer.md
Name: instruction_input_issuer

Overview:
- Producer-side driver for the instruction input interface (move_from/move_valid/move_ack and immediate/immediate_valid/immediate_ack).
- Accepts decoded instruction-input requests from the decode stage over a valid/ready stream and buffers them in a small in-order FIFO.
- Issues each request on the move channel, the immediate channel, or both, and holds it there until the consumer acknowledges.

Parameters:
- ADDR_WIDTH, 8, width of move_from source address.
- DATA_WIDTH, 32, width of immediate value.
- DEPTH, 4, FIFO entries; power of two, >= 2.
- COUNT_WIDTH, 16, width of issue counters.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream request valid.
- in_ready  output  1  upstream may transfer; equals !fifo_full.
- in_op  input  2  00 NOP, 01 MOVE, 10 IMM, 11 MOVE_IMM.
- in_move_from  input  ADDR_WIDTH  source address for MOVE/MOVE_IMM.
- in_immediate  input  DATA_WIDTH  value for IMM/MOVE_IMM.
- move_from  output  ADDR_WIDTH  interface move address.
- move_valid  output  1  interface move valid.
- move_ack  input  1  interface move acknowledge.
- immediate  output  DATA_WIDTH  interface immediate value.
- immediate_valid  output  1  interface immediate valid.
- immediate_ack  input  1  interface immediate acknowledge.
- busy  output  1  FIFO non-empty or any channel valid.
- fifo_level  output  $clog2(DEPTH)+1  current FIFO occupancy.
- move_count  output  COUNT_WIDTH  completed move handshakes, wraps.
- imm_count  output  COUNT_WIDTH  completed immediate handshakes, wraps.

Behaviour:
- Reset (async assert, sync release) values: all outputs 0 except in_ready=1; FIFO empty; FSM in IDLE.
- Reset mid-handshake drops the pending request without completing it; counters are cleared.
- Upstream transfer occurs on in_valid && in_ready at a rising edge.
  - NOP is accepted but not stored.
  - Other ops store {op, in_move_from, in_immediate}.
  - in_ready is not raised by a same-cycle pop when the FIFO is full.
- Channel handshake completes on a rising edge with valid && ack.
  - While valid && !ack, the data and valid outputs stay stable.
  - ack while valid=0 is ignored.
  - Each channel completes independently.
- FSM states IDLE and ISSUE.
  - IDLE: if the FIFO is non-empty, pop the head on this edge and load move_from and immediate from it. Set move_valid = op[0] and immediate_valid = op[1]. Go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: clear each valid on its completing edge. The request is done when no valid remains after this edge; both completing in the same cycle counts.
  - On the done edge with the FIFO non-empty (counting entries already present, not same-cycle pushes), pop and re-arm on that same edge. This gives no bubble, so sustained throughput is 1 request/cycle with ack tied high.
  - On the done edge with the FIFO empty, go to IDLE.
  - For MOVE_IMM, the two channels may complete in either order. The next request is not issued until both have completed.
- Latency: a request accepted at edge k into an empty FIFO while in IDLE has its valid(s) high after edge k+1.
- FIFO is in-order, with pointers one bit wider than the index and wrap-around modulo DEPTH.
  - fifo_level = wr_ptr - rd_ptr.
  - Simultaneous push and pop when not full leaves the level unchanged.
- Counters increment by 1 per completed channel handshake and wrap from 2^COUNT_WIDTH-1 to 0.

Test Plan:
- Reset then push MOVE from=0x12 with move_ack held 0 for 3 cycles then 1 -> move_valid high after edge k+1, move_from=0x12 stable throughout, move_valid low after the ack edge, move_count=1, busy=0.
- Push IMM 0xDEADBEEF, MOVE 0x05 and NOP back-to-back with both acks tied 1 -> immediate_valid high 1 cycle, then move_valid high the next cycle with no bubble, NOP never issued, imm_count=1, move_count=1.
- Push MOVE_IMM from=0x3, imm=0x7; assert immediate_ack 2 cycles before move_ack -> immediate_valid drops first, move_valid stays until its ack, and the next queued request is only issued on the move-ack edge.
- With both acks 0, push 5 requests (DEPTH=4) -> 1 request issued, 4 buffered, fifo_level=4, in_ready=0; the 6th push stalls until the first completion.
- Assert rst_n=0 mid-MOVE_IMM with 2 entries queued -> valids, fifo_level and counters are 0 immediately; after release in_ready=1 and no stale request is issued.
- Set move_count to 2^16-1 by driving 65535 move handshakes (or force), then complete 1 more -> move_count=0.
